// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin arbiter sharing one ready/valid output channel
// between N requesters, locking the channel for a whole packet (until the
// granted requester's last beat is accepted). The output side is forward
// registered, so s_valid/s_data/s_last are flop outputs.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_m_valid[N]       per-requester valid
//   i_m_data[N*WIDTH]  requester i data on bits [i*WIDTH +: WIDTH]
//   i_m_last[N]        per-requester end-of-packet, qualified by valid
//   o_m_ready[N]       per-requester ready, at most one bit set
//   o_s_valid/o_s_data/o_s_last  registered output beat
//   i_s_ready          downstream ready
//   o_grant_id         current / most recent granted requester
//   o_busy             high while a packet holds the channel
module rv_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N-1:0]       i_m_valid,
  input  logic [N*WIDTH-1:0] i_m_data,
  input  logic [N-1:0]       i_m_last,
  output logic [N-1:0]       o_m_ready,
  output logic               o_s_valid,
  output logic [WIDTH-1:0]   o_s_data,
  output logic               o_s_last,
  input  logic               i_s_ready,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;
  logic             r_s_last;

  logic [IDW-1:0]   w_cand [N];
  logic [IDW-1:0]   w_pick;
  logic             w_any;
  logic             w_out_free;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;

  // Search order: w_cand[0] is the requester right after the last grant,
  // wrapping modulo N; w_cand[N-1] is the last grant itself.
  for (genvar k = 0; k < N; k++) begin : g_cand
    assign w_cand[k] = IDW'((32'(r_grant) + k + 1) % N);
  end

  // Walk from lowest priority to highest so the earliest candidate wins.
  always_comb begin
    w_pick = r_grant;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_m_valid[w_cand[k]]) w_pick = w_cand[k];
    end
  end

  assign w_any = |i_m_valid;

  // Output register can take a beat when empty or draining this cycle.
  // Only registered state and i_s_ready feed m_ready, never m_valid.
  assign w_out_free = !r_s_valid || i_s_ready;

  always_comb begin
    o_m_ready = '0;
    if (r_state == ST_BUSY) o_m_ready[r_grant] = w_out_free;
  end

  assign w_accept   = (r_state == ST_BUSY) && i_m_valid[r_grant] && w_out_free;
  assign w_sel_data = i_m_data[r_grant*WIDTH +: WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= IDW'(N - 1);
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_last  <= 1'b0;
    end else begin
      // Output register: load wins over drain so a simultaneous
      // drain+refill keeps s_valid high (full throughput).
      if (w_accept) begin
        r_s_valid <= 1'b1;
        r_s_data  <= w_sel_data;
        r_s_last  <= i_m_last[r_grant];
      end else if (i_s_ready) begin
        r_s_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // grant_id holds on exit; it is the base of the next search.
          if (w_accept && i_m_last[r_grant]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_s_valid  = r_s_valid;
  assign o_s_data   = r_s_data;
  assign o_s_last   = r_s_last;
  assign o_grant_id = r_grant;
  assign o_busy     = (r_state == ST_BUSY);

endmodule

// File: doc/rv_rr_arbiter.md
# rv_rr_arbiter

Round-robin arbiter that shares one ready/valid output channel between `N` ready/valid requesters, with packet locking on a `last` flag. It sits in front of a shared downstream stage, typically a backward-registered or skid stage. It drives a forward-registered output so that `s_valid`, `s_data` and `s_last` are flop outputs. Arbitration is fair round-robin at packet granularity: a granted requester holds the channel until its `last` beat is accepted.

## Interface
- `WIDTH`, 8, data width per requester
- `N`, 4, number of requesters (2..16)
- `IDW`, `$clog2(N)`, width of grant index
- `clk`  in  1  single clock; all flops on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `m_valid`  in  N  per-requester valid
- `m_data`  in  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- `m_last`  in  N  per-requester end-of-packet flag, qualified by `m_valid`
- `m_ready`  out  N  per-requester ready; at most one bit high
- `s_valid`  out  1  registered output valid
- `s_data`  out  WIDTH  registered output data
- `s_last`  out  1  registered output last
- `s_ready`  in  1  downstream ready
- `grant_id`  out  IDW  index of current/last granted requester
- `busy`  out  1  high while a packet is locked (state BUSY)

## Operation
- Reset values: `s_valid`=0, `s_data`=0, `s_last`=0, `busy`=0, `grant_id`=N-1 (so first grant search starts at 0), `m_ready`=0.
- States: IDLE, BUSY. State equals `busy`.
- IDLE:
  - If any `m_valid` is high, pick the first requester with valid set, scanning `grant_id+1`, `grant_id+2`, … modulo N (wrap-around).
  - Register the pick into `grant_id` and go to BUSY.
  - `m_ready` is all zeros in IDLE, so no beat is consumed.
- BUSY:
  - `m_ready[grant_id] = !s_valid || s_ready`; all other bits are 0.
  - Accept = `m_valid[grant_id] && m_ready[grant_id]`.
  - On accept, the output register loads `m_data` slice, `m_last` bit, and `s_valid`=1.
  - Else if `s_ready`, `s_valid` clears. `s_data`/`s_last` hold when not loading.
  - On accept with `m_last[grant_id]`=1, go to IDLE. `grant_id` holds, and becomes the base for the next round-robin search.
  - Gaps (`m_valid` low mid-packet) keep BUSY; no other requester is served.
- Output channel rule: once `s_valid`=1, `s_data`/`s_last` are stable until `s_ready`=1 at a clock edge.
- Simultaneous output drain and refill in one cycle (`s_valid && s_ready && accept`): the new beat is loaded and `s_valid` stays 1. This gives full throughput.
- Requesters are not required to hold `m_valid`. The arbiter does not latch requests: a requester that drops valid in IDLE is not granted.
- Reset mid-packet: the state returns to IDLE, the output register clears, and the in-flight beat is dropped. No recovery beyond this.

## Timing
- Grant latency: `m_valid` high at edge k in IDLE → BUSY with `grant_id` set after edge k+1.
  - First `m_ready` occurs in cycle k+1.
  - First `s_valid` occurs after edge k+2.
- Throughput inside a packet: one beat per cycle while `s_ready`=1.
- Packet turnaround costs exactly one IDLE cycle (no `m_ready`) between packets.
- `m_ready` is combinational from `busy`, `grant_id`, `s_valid` and `s_ready`. There is no combinational path from `m_valid` to `m_ready`.
- Data path latency: one cycle from accepted input beat to `s_valid`.

## Test plan
- Single packet: after reset, requester 2 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33) with `s_ready`=1.
  - `grant_id`=2.
  - `s_data` shows 0x11, 0x22, 0x33 on consecutive cycles, with `s_last` only on 0x33.
  - `busy` then drops.
- Round-robin fairness: all 4 requesters hold valid continuously with 1-beat packets (last=1).
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Each is followed by one IDLE cycle.
  - Output data matches requester index.
- Wrap-around: `grant_id`=3, then requesters 1 and 2 request.
  - Next grant is 1, then 2.
- Backpressure: during a 4-beat packet from requester 0, hold `s_ready`=0 for 3 cycles on beat 2.
  - `s_data` is held stable.
  - `m_ready[0]`=0 while `s_valid` is 1 and `s_ready` is 0.
  - No beat is lost or duplicated; 4 beats are delivered in order.
- Packet lock: requester 1 is mid-packet with a valid gap of 2 cycles while requester 3 is valid.
  - `m_ready[3]` stays 0 until requester 1's last beat is accepted.
  - Then `grant_id`=3.
- Async reset mid-packet: assert `rst_n`=0 between edges while `s_valid`=1.
  - `s_valid`, `busy` and `m_ready` go to 0 immediately, and `grant_id`=N-1.
  - After release, a request from requester 0 is granted first.
